// File: rtl/acc_coproc_port.sv
// -----------------------------------------------------------------------------
// acc_coproc_port
//   Decoupled coprocessor port between the CPU core and the model accelerator.
//   ACC instructions push (Rm,Rn) pairs into an operand queue. A small
//   sequencer (IDLE/SEND/WAIT) hands each pair to the model over valid/ready.
//   It then waits for the prediction and pushes it into a result queue, which
//   the CPU pops on demand. The core stalls only when a queue cannot serve the
//   request in the current cycle.
//
//   Ports
//     clk_i, rst_n              clock, async active-low reset
//     issue_i, rm_i, rn_i       CPU pushes an operand pair
//     get_i, pred_o             CPU pops a prediction (zero-extended)
//     stall_o                   freeze core this cycle (combinational)
//     m_valid_o/m_ready_i       operand handshake to model, m_rm_o/m_rn_o data
//     r_valid_i, r_data_i       prediction pulse from model
//     busy_o                    any queue nonempty or sequencer active
//     timeout_o                 sticky: a model request was aborted
//     op_count_o                operand queue occupancy
// -----------------------------------------------------------------------------

// Simple circular FIFO. Callers guard push/pop, so there are no overflow checks.
module acc_cp_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [AW-1:0]           wr_q, rd_q;
    logic [AW:0]             cnt_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= wr_q + 1'b1;   // DEPTH is a power of 2: natural wrap
            end
            if (pop_i)
                rd_q <= rd_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;
endmodule

module acc_coproc_port #(
    parameter int DATA_WIDTH = 16,
    parameter int PRED_WIDTH = 4,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_n,
    input  logic                      issue_i,
    input  logic [DATA_WIDTH-1:0]     rm_i,
    input  logic [DATA_WIDTH-1:0]     rn_i,
    input  logic                      get_i,
    output logic [DATA_WIDTH-1:0]     pred_o,
    output logic                      stall_o,
    output logic                      m_valid_o,
    input  logic                      m_ready_i,
    output logic [DATA_WIDTH-1:0]     m_rm_o,
    output logic [DATA_WIDTH-1:0]     m_rn_o,
    input  logic                      r_valid_i,
    input  logic [PRED_WIDTH-1:0]     r_data_i,
    output logic                      busy_o,
    output logic                      timeout_o,
    output logic [$clog2(DEPTH):0]    op_count_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    // Abort fires in the TIMEOUT-th WAIT cycle (timer counts 0..TIMEOUT-1).
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            timeout_q, timeout_d;

    logic                    op_push, op_pop, op_empty, op_full;
    logic [2*DATA_WIDTH-1:0] op_head;
    logic [CW-1:0]           op_cnt;

    logic                    res_push, res_pop, res_empty, res_full;
    logic [PRED_WIDTH-1:0]   res_head, res_wdata;
    logic [CW-1:0]           res_cnt;

    logic                    send;

    // ---------------- queues ----------------
    acc_cp_fifo #(.W(2*DATA_WIDTH), .DEPTH(DEPTH)) u_opq (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .push_i  (op_push),
        .pop_i   (op_pop),
        .wdata_i ({rm_i, rn_i}),
        .rdata_o (op_head),
        .count_o (op_cnt)
    );

    acc_cp_fifo #(.W(PRED_WIDTH), .DEPTH(DEPTH)) u_resq (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .push_i  (res_push),
        .pop_i   (res_pop),
        .wdata_i (res_wdata),
        .rdata_o (res_head),
        .count_o (res_cnt)
    );

    assign op_empty  = (op_cnt == '0);
    assign op_full   = (op_cnt == CW'(DEPTH));
    assign res_empty = (res_cnt == '0);
    assign res_full  = (res_cnt == CW'(DEPTH));

    // A full operand queue refuses the push even if the sequencer pops this cycle.
    assign op_push = issue_i & ~op_full;
    assign res_pop = get_i & ~res_empty;
    assign stall_o = (issue_i & op_full) | (get_i & res_empty);

    always_comb begin
        pred_o = '0;
        if (res_pop)
            pred_o[PRED_WIDTH-1:0] = res_head;
    end

    // ---------------- sequencer ----------------
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        timeout_d = timeout_q;
        op_pop    = 1'b0;
        res_push  = 1'b0;
        res_wdata = '0;
        send      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Only one pair is ever in flight, so a free result slot
                // now is still free when that pair's prediction returns.
                if (!op_empty && !res_full)
                    state_d = S_SEND;
            end
            S_SEND: begin
                send = 1'b1;
                if (m_ready_i) begin
                    op_pop  = 1'b1;
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_valid_i) begin
                    res_push  = 1'b1;
                    res_wdata = r_data_i;
                    timer_d   = '0;
                    state_d   = S_IDLE;
                end else if (timer_q == T_LAST) begin
                    // Abort: a zero prediction keeps the result order aligned with issue order.
                    res_push  = 1'b1;
                    timeout_d = 1'b1;
                    timer_d   = '0;
                    state_d   = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign m_valid_o  = send;
    assign m_rm_o     = send ? op_head[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign m_rn_o     = send ? op_head[DATA_WIDTH-1:0]            : '0;
    assign busy_o     = ~op_empty | ~res_empty | (state_q != S_IDLE);
    assign timeout_o  = timeout_q;
    assign op_count_o = op_cnt;
endmodule

// File: tb/tb_acc_coproc_port.sv
module tb_acc_coproc_port;
    localparam int DW      = 16;
    localparam int PW      = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 4;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rst_n = 1'b0;
    logic          issue_i = 1'b0, get_i = 1'b0, m_ready_i = 1'b0, r_valid_i = 1'b0;
    logic [DW-1:0] rm_i = '0, rn_i = '0;
    logic [PW-1:0] r_data_i = '0;
    logic [DW-1:0] pred_o, m_rm_o, m_rn_o;
    logic          stall_o, m_valid_o, busy_o, timeout_o;
    logic [CW-1:0] op_count_o;

    always #5 clk_i = ~clk_i;

    acc_coproc_port #(.DATA_WIDTH(DW), .PRED_WIDTH(PW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .issue_i(issue_i), .rm_i(rm_i), .rn_i(rn_i),
        .get_i(get_i), .pred_o(pred_o), .stall_o(stall_o), .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i), .m_rm_o(m_rm_o), .m_rn_o(m_rn_o), .r_valid_i(r_valid_i),
        .r_data_i(r_data_i), .busy_o(busy_o), .timeout_o(timeout_o), .op_count_o(op_count_o)
    );

    // Transaction-level reference: queued pairs, queued predictions, one in-flight request.
    logic [2*DW-1:0] opq[$];
    logic [PW-1:0]   resq[$];
    logic [PW-1:0]   rd_list[$];   // scripted model responses, else random
    bit              infl, infl_resp, exp_to, prev_pend;
    int              infl_dly, wcnt, resp_mode;   // 0 random, 1 respond after 2, 2 never
    int              n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    task automatic step(input logic iss, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic gt, input logic mr, input logic rv, input logic [PW-1:0] rd);
        logic [DW-1:0] ep;
        logic          hs, acc, pr, push;
        logic [PW-1:0] pd;
        issue_i = iss; rm_i = a; rn_i = b; get_i = gt; m_ready_i = mr;
        r_valid_i = rv; r_data_i = rd;
        #1;
        chk("stall", 32'(stall_o), 32'((iss && opq.size() == DEPTH) || (gt && resq.size() == 0)));
        chk("op_count", 32'(op_count_o), 32'(opq.size()));
        ep = '0;
        if (gt && resq.size() > 0) ep = DW'(resq[0]);
        chk("pred", 32'(pred_o), 32'(ep));
        chk("busy", 32'(busy_o), 32'(opq.size() > 0 || resq.size() > 0 || infl));
        chk("timeout", 32'(timeout_o), 32'(exp_to));
        if (opq.size() == 0 || infl) chk("m_valid_idle", 32'(m_valid_o), 32'(0));
        else if (prev_pend)          chk("m_valid_hold", 32'(m_valid_o), 32'(1));
        if (m_valid_o && opq.size() > 0) chk("m_pair", {m_rm_o, m_rn_o}, opq[0]);

        acc  = iss && opq.size() < DEPTH;
        hs   = m_valid_o && mr;
        pr   = gt && resq.size() > 0;
        push = 1'b0;
        pd   = '0;
        if (infl) begin
            if (rv) begin push = 1'b1; pd = rd; end
            else if (wcnt == TIMEOUT - 1) begin push = 1'b1; exp_to = 1'b1; end
            else wcnt++;
        end
        prev_pend = m_valid_o && !mr;
        @(posedge clk_i);
        if (pr) void'(resq.pop_front());
        if (push) begin resq.push_back(pd); infl = 1'b0; end
        if (hs && opq.size() > 0) begin
            void'(opq.pop_front());
            infl = 1'b1;
            wcnt = 0;
            case (resp_mode)
                0:       begin infl_resp = ($urandom_range(7) != 0); infl_dly = $urandom_range(2); end
                1:       begin infl_resp = 1'b1; infl_dly = 2; end
                default: begin infl_resp = 1'b0; infl_dly = 0; end
            endcase
        end
        if (acc) opq.push_back({a, b});
        @(negedge clk_i);
    endtask

    // One cycle with the model side driven from the reference's in-flight state.
    task automatic cyc(input logic iss, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic gt, input logic mr);
        logic          rv;
        logic [PW-1:0] rd;
        rv = infl && infl_resp && (wcnt == infl_dly);
        if (!infl && resp_mode == 0 && $urandom_range(7) == 0) rv = 1'b1;   // stray pulse
        rd = PW'($urandom);
        if (rv && infl && rd_list.size() > 0) rd = rd_list.pop_front();
        step(iss, a, b, gt, mr, rv, rd);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (opq.size() == 0 && resq.size() == 0 && !infl) break;
            cyc(1'b0, '0, '0, resq.size() > 0, 1'b1);
        end
        chk("drain_idle", 32'(busy_o), 32'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        issue_i = 0; get_i = 0; m_ready_i = 0; r_valid_i = 0; rm_i = '0; rn_i = '0; r_data_i = '0;
        #1;
        opq.delete(); resq.delete(); rd_list.delete();
        infl = 0; exp_to = 0; prev_pend = 0; wcnt = 0;
        chk("rst_stall", 32'(stall_o), 32'(0));
        chk("rst_pred", 32'(pred_o), 32'(0));
        chk("rst_m_valid", 32'(m_valid_o), 32'(0));
        chk("rst_m_pair", {m_rm_o, m_rn_o}, 32'(0));
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_timeout", 32'(timeout_o), 32'(0));
        chk("rst_op_count", 32'(op_count_o), 32'(0));
        @(negedge clk_i);
        rst_n = 1'b1;
    endtask

    initial begin
        resp_mode = 1;
        @(negedge clk_i);
        do_reset();

        // Single op and minimum latency: m_valid two cycles after issue.
        rd_list.push_back(4'h9);
        cyc(1'b1, 16'd3, 16'd5, 1'b0, 1'b1);
        chk("lat_n1", 32'(m_valid_o), 32'(0));
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        chk("lat_n2", 32'(m_valid_o), 32'(1));
        for (int i = 0; i < 20 && resq.size() == 0; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1);
        chk("single_ready", 32'(resq.size()), 32'(1));
        cyc(1'b0, '0, '0, 1'b1, 1'b1);   // pops 9

        // Back-pressure: model never ready, fifth issue stalls.
        for (int i = 0; i < 5; i++) cyc(1'b1, DW'(i + 1), DW'(i + 16), 1'b0, 1'b0);
        chk("bp_count", 32'(op_count_o), 32'(DEPTH));
        drain();

        // Early get: stall until the prediction lands.
        cyc(1'b1, 16'd7, 16'd7, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (resq.size() > 0) begin cyc(1'b0, '0, '0, 1'b1, 1'b1); break; end
            cyc(1'b0, '0, '0, 1'b1, 1'b1);
        end
        drain();

        // Ordering.
        rd_list.push_back(4'd7); rd_list.push_back(4'd8); rd_list.push_back(4'd9);
        for (int i = 1; i <= 3; i++) cyc(1'b1, DW'(i), DW'(i), 1'b0, 1'b1);
        drain();

        // Timeout, then a normal op.
        resp_mode = 2;
        cyc(1'b1, 16'h11, 16'h22, 1'b0, 1'b1);
        for (int i = 0; i < 20 && !exp_to; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1);
        chk("to_flag", 32'(timeout_o), 32'(1));
        resp_mode = 1;
        drain();
        cyc(1'b1, 16'h33, 16'h44, 1'b0, 1'b1);
        drain();

        // Random traffic.
        resp_mode = 0;
        for (int i = 0; i < 600; i++)
            cyc(1'($urandom_range(1)), DW'($urandom), DW'($urandom),
                ($urandom_range(2) == 0), 1'($urandom_range(1)));
        resp_mode = 1;
        drain();

        // Reset mid-WAIT with two ops queued; a late r_valid is ignored.
        resp_mode = 2;
        cyc(1'b1, 16'h55, 16'h66, 1'b0, 1'b1);
        for (int i = 0; i < 10 && !infl; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1);
        cyc(1'b1, 16'h77, 16'h88, 1'b0, 1'b0);
        cyc(1'b1, 16'h99, 16'haa, 1'b0, 1'b0);
        do_reset();
        resp_mode = 1;
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 4'h5);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        chk("post_rst_busy", 32'(busy_o), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
